// File: rtl/pixel_readout_packer_pkg.sv
// rtl/pixel_readout_packer_pkg.sv - shared types and default geometry for the pixel readout packer
// Purpose: readout mode/state enums, default array geometry, lane counter width helper.
// Ports: none (package).
package pixel_readout_packer_pkg;

  localparam int PIXEL_BITS         = 8;
  localparam int PIXEL_ARRAY_WIDTH  = 8;
  localparam int PIXEL_ARRAY_HEIGHT = 8;
  localparam int OUTPUT_BUS_WIDTH   = 4;

  typedef enum logic {
    READ_FULL     = 1'b0,
    READ_DECIMATE = 1'b1
  } readout_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } readout_state_t;

  // A single-lane bus still needs a one-bit lane counter.
  function automatic int lane_bits(input int bus_width);
    return (bus_width > 1) ? $clog2(bus_width) : 1;
  endfunction

endpackage

// File: rtl/pixel_readout_packer_lane_packer.sv
// rtl/pixel_readout_packer_lane_packer.sv - gathers kept pixels into bus beats behind a valid/ready output register
// Purpose: lane counter, lane registers and the single output beat register.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_clear                rewinds the lane counter at frame start
//   i_push, i_data         kept pixel to store in the current lane
//   i_first                pixel sits at column 0 (row start candidate)
//   i_last                 pixel is the last kept pixel of the frame
//   o_can_accept           output register can take a new beat this cycle
//   o_valid, i_ready       output handshake
//   o_data                 packed beat, lane 0 in the low bits
//   o_row_start, o_frame_end  beat qualifiers
module lane_packer #(
  parameter int PIXEL_BITS = 8,
  parameter int BUS_WIDTH  = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_clear,
  input  logic                             i_push,
  input  logic [PIXEL_BITS-1:0]            i_data,
  input  logic                             i_first,
  input  logic                             i_last,
  output logic                             o_can_accept,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [BUS_WIDTH*PIXEL_BITS-1:0]  o_data,
  output logic                             o_row_start,
  output logic                             o_frame_end
);
  import pixel_readout_packer_pkg::*;

  localparam int             LW        = lane_bits(BUS_WIDTH);
  localparam logic [LW-1:0]  LANE_LAST = LW'(BUS_WIDTH - 1);

  logic [LW-1:0]                        r_lane;
  logic [BUS_WIDTH-1:0][PIXEL_BITS-1:0] r_lanes;
  logic                                 r_first;
  logic                                 r_valid;
  logic [BUS_WIDTH*PIXEL_BITS-1:0]      r_data;
  logic                                 r_row_start;
  logic                                 r_frame_end;

  logic                                 w_beat_done;
  logic                                 w_row_start;
  logic [BUS_WIDTH-1:0][PIXEL_BITS-1:0] w_beat;

  assign w_beat_done = i_push && (r_lane == LANE_LAST);
  // Row-start belongs to whichever pixel landed in lane 0 of this beat.
  assign w_row_start = (r_lane == '0) ? i_first : r_first;

  // The completing pixel bypasses its lane register straight into the beat.
  always_comb begin
    w_beat                = r_lanes;
    w_beat[BUS_WIDTH-1]   = i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lane      <= '0;
      r_lanes     <= '0;
      r_first     <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_row_start <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      if (i_clear) begin
        r_lane <= '0;
      end else if (i_push) begin
        r_lanes[r_lane] <= i_data;
        if (r_lane == '0) begin
          r_first <= i_first;
        end
        r_lane <= w_beat_done ? '0 : r_lane + 1'b1;
      end

      // A push only happens when o_can_accept was high, so a pending beat is never overwritten.
      if (w_beat_done) begin
        r_valid     <= 1'b1;
        r_data      <= w_beat;
        r_row_start <= w_row_start;
        r_frame_end <= i_last;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_can_accept = !r_valid || i_ready;
  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_row_start  = r_row_start;
  assign o_frame_end  = r_frame_end;

endmodule

// File: rtl/pixel_readout_packer.sv
// rtl/pixel_readout_packer.sv - frame-level readout FSM, raster counters and decimation keep logic
// Purpose: sequences one frame of pixels into bus beats, full resolution or 2x2 decimated.
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_frame_start, i_mode               arm a frame; mode sampled with the start pulse
//   i_in_valid, o_in_ready, i_in_data   raster-order pixel input stream
//   o_out_valid, i_out_ready, o_out_data  beat output stream
//   o_out_row_start, o_out_frame_end    beat qualifiers
//   o_frame_finished                    one-cycle pulse after the final beat leaves
//   o_busy                              frame in progress
//   o_err_overrun                       one-cycle pulse for an ignored frame start
module pixel_readout_packer #(
  parameter int PIXEL_BITS   = pixel_readout_packer_pkg::PIXEL_BITS,
  parameter int ARRAY_WIDTH  = pixel_readout_packer_pkg::PIXEL_ARRAY_WIDTH,
  parameter int ARRAY_HEIGHT = pixel_readout_packer_pkg::PIXEL_ARRAY_HEIGHT,
  parameter int BUS_WIDTH    = pixel_readout_packer_pkg::OUTPUT_BUS_WIDTH
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_frame_start,
  input  logic                             i_mode,
  input  logic                             i_in_valid,
  output logic                             o_in_ready,
  input  logic [PIXEL_BITS-1:0]            i_in_data,
  output logic                             o_out_valid,
  input  logic                             i_out_ready,
  output logic [BUS_WIDTH*PIXEL_BITS-1:0]  o_out_data,
  output logic                             o_out_row_start,
  output logic                             o_out_frame_end,
  output logic                             o_frame_finished,
  output logic                             o_busy,
  output logic                             o_err_overrun
);
  import pixel_readout_packer_pkg::*;

  localparam int            CW            = $clog2(ARRAY_WIDTH);
  localparam int            RW            = $clog2(ARRAY_HEIGHT);
  localparam logic [CW-1:0] COL_LAST      = CW'(ARRAY_WIDTH - 1);
  localparam logic [CW-1:0] COL_LAST_KEPT = CW'(ARRAY_WIDTH - 2);
  localparam logic [RW-1:0] ROW_LAST      = RW'(ARRAY_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_LAST_KEPT = RW'(ARRAY_HEIGHT - 2);

  readout_state_t r_state;
  readout_state_t w_next_state;
  readout_mode_t  r_mode;
  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic           r_finished;
  logic           r_err;

  logic w_start;
  logic w_in_fire;
  logic w_keep;
  logic w_last_pixel;
  logic w_last_kept;
  logic w_can_accept;
  logic w_drain_done;

  assign w_start      = i_frame_start && (r_state == IDLE);
  assign w_in_fire    = i_in_valid && o_in_ready;
  assign w_last_pixel = (r_col == COL_LAST) && (r_row == ROW_LAST);
  // Decimation keeps the top-left pixel of every 2x2 block.
  assign w_keep       = (r_mode == READ_FULL) || (!r_col[0] && !r_row[0]);
  assign w_last_kept  = (r_mode == READ_FULL) ? w_last_pixel
                                              : ((r_col == COL_LAST_KEPT) && (r_row == ROW_LAST_KEPT));
  // In decimated mode the final beat may already be gone before the raster ends,
  // so the drain also completes on an empty output register.
  assign w_drain_done = (r_state == DRAIN) && (!o_out_valid || i_out_ready);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_frame_start)                w_next_state = ACTIVE;
      ACTIVE:  if (w_in_fire && w_last_pixel)    w_next_state = DRAIN;
      DRAIN:   if (w_drain_done)                 w_next_state = IDLE;
      default:                                   w_next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_in_ready = 1'b0;
    o_busy     = (r_state != IDLE);
    if (r_state == ACTIVE) begin
      o_in_ready = w_can_accept;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode     <= READ_FULL;
      r_col      <= '0;
      r_row      <= '0;
      r_finished <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_start) begin
        r_mode <= readout_mode_t'(i_mode);
        r_col  <= '0;
        r_row  <= '0;
      end else if (w_in_fire) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      r_finished <= w_drain_done;
      r_err      <= i_frame_start && (r_state != IDLE);
    end
  end

  assign o_frame_finished = r_finished;
  assign o_err_overrun    = r_err;

  lane_packer #(
    .PIXEL_BITS (PIXEL_BITS),
    .BUS_WIDTH  (BUS_WIDTH)
  ) u_lane_packer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (w_start),
    .i_push       (w_in_fire && w_keep),
    .i_data       (i_in_data),
    .i_first      (r_col == '0),
    .i_last       (w_last_kept),
    .o_can_accept (w_can_accept),
    .o_valid      (o_out_valid),
    .i_ready      (i_out_ready),
    .o_data       (o_out_data),
    .o_row_start  (o_out_row_start),
    .o_frame_end  (o_out_frame_end)
  );

endmodule

// File: tb/tb_pixel_readout_packer.sv
// tb/tb_pixel_readout_packer.sv - directed self-checking bench for pixel_readout_packer
module tb_pixel_readout_packer;

  localparam int PB = 8;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int BW = 4;
  localparam int NPIX = W * H;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_frame_start;
  logic             i_mode;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [PB-1:0]    i_in_data;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [BW*PB-1:0] o_out_data;
  logic             o_out_row_start;
  logic             o_out_frame_end;
  logic             o_frame_finished;
  logic             o_busy;
  logic             o_err_overrun;

  pixel_readout_packer #(
    .PIXEL_BITS   (PB),
    .ARRAY_WIDTH  (W),
    .ARRAY_HEIGHT (H),
    .BUS_WIDTH    (BW)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_frame_start    (i_frame_start),
    .i_mode           (i_mode),
    .i_in_valid       (i_in_valid),
    .o_in_ready       (o_in_ready),
    .i_in_data        (i_in_data),
    .o_out_valid      (o_out_valid),
    .i_out_ready      (i_out_ready),
    .o_out_data       (o_out_data),
    .o_out_row_start  (o_out_row_start),
    .o_out_frame_end  (o_out_frame_end),
    .o_frame_finished (o_frame_finished),
    .o_busy           (o_busy),
    .o_err_overrun    (o_err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW*PB-1:0] d;
    logic             rs;
    logic             fe;
    int               cyc;
  } beat_t;

  beat_t            beats[$];
  logic [BW*PB-1:0] exp_d[$];
  logic             exp_rs[$];
  logic             exp_fe[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pix_idx = 0;
  int in_hs   = 0;
  int fin_cnt = 0;
  int fin_cyc = 0;
  int err_cnt = 0;
  logic fin_busy = 1'b0;
  int start_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples the cycle just before the rising edge, then advances to the next falling edge.
  task automatic tick();
    logic fire;
    #1;
    fire = i_in_valid && o_in_ready;
    if (fire) in_hs++;
    if (o_out_valid && i_out_ready) beats.push_back('{o_out_data, o_out_row_start, o_out_frame_end, cyc});
    if (o_frame_finished) begin
      fin_cnt++;
      fin_cyc  = cyc;
      fin_busy = o_busy;
    end
    if (o_err_overrun) err_cnt++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (fire) pix_idx++;
    i_in_data = pix_idx[PB-1:0];
  endtask

  // Reference: pixel value = raster index; kept pixels gathered four to a beat.
  task automatic build_model(input logic m);
    logic [BW*PB-1:0] cur;
    logic             rs;
    int               lane;
    exp_d.delete(); exp_rs.delete(); exp_fe.delete();
    lane = 0; cur = '0; rs = 1'b0;
    for (int idx = 0; idx < NPIX; idx++) begin
      int r, c;
      r = idx / W;
      c = idx % W;
      if (!m || ((r % 2 == 0) && (c % 2 == 0))) begin
        cur[lane*PB +: PB] = idx[PB-1:0];
        if (lane == 0) rs = (c == 0);
        lane++;
        if (lane == BW) begin
          exp_d.push_back(cur);
          exp_rs.push_back(rs);
          exp_fe.push_back(1'b0);
          lane = 0;
        end
      end
    end
    exp_fe[exp_fe.size()-1] = 1'b1;
  endtask

  task automatic run_frame(input logic m, input bit stall_en, input bit ovr_en, input int abort_at,
                           output int s_cyc);
    int  stall_left;
    bit  ovr_done;
    beats.delete();
    in_hs = 0; fin_cnt = 0; err_cnt = 0; pix_idx = 0;
    i_in_data     = '0;
    i_frame_start = 1'b1;
    i_mode        = m;
    i_in_valid    = 1'b1;
    i_out_ready   = 1'b1;
    s_cyc         = cyc;
    tick();
    i_frame_start = 1'b0;
    chk("busy_after_start", o_busy, 1);
    stall_left = 5;
    ovr_done   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (fin_cnt > 0 || pix_idx == abort_at) break;
      i_out_ready = 1'b1;
      if (stall_en && beats.size() == 2 && o_out_valid && stall_left > 0) begin
        i_out_ready = 1'b0;
        stall_left--;
      end
      i_frame_start = 1'b0;
      if (ovr_en && pix_idx == 10 && !ovr_done) begin
        i_frame_start = 1'b1;
        i_mode        = ~m;
        ovr_done      = 1'b1;
      end
      i_in_valid = (pix_idx < NPIX);
      if (!i_out_ready) begin
        #1;
        chk("stall_data_hold", o_out_data, 32'h0B0A0908);
        chk("stall_in_ready", o_in_ready, 0);
      end
      tick();
    end
    i_frame_start = 1'b0;
  endtask

  task automatic check_frame(input logic m, input bit timing, input int s_cyc, input int exp_err);
    int n;
    build_model(m);
    chk("beat_count", beats.size(), exp_d.size());
    n = (beats.size() < exp_d.size()) ? beats.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("beat%0d_data", i), beats[i].d, exp_d[i]);
      chk($sformatf("beat%0d_row_start", i), beats[i].rs, exp_rs[i]);
      chk($sformatf("beat%0d_frame_end", i), beats[i].fe, exp_fe[i]);
    end
    chk("input_handshakes", in_hs, NPIX);
    chk("finished_pulse_count", fin_cnt, 1);
    chk("busy_low_at_finished", fin_busy, 0);
    chk("err_overrun_cycles", err_cnt, exp_err);
    if (timing && beats.size() == exp_d.size()) begin
      chk("first_beat_latency", beats[0].cyc - s_cyc, 5);
      chk("beat_throughput", beats[beats.size()-1].cyc - beats[0].cyc, 28);
      chk("finished_latency", fin_cyc - beats[beats.size()-1].cyc, 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_data"}, o_out_data, 0);
    chk({tag, "_out_valid"}, o_out_valid, 0);
    chk({tag, "_row_start"}, o_out_row_start, 0);
    chk({tag, "_frame_end"}, o_out_frame_end, 0);
    chk({tag, "_finished"}, o_frame_finished, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_err_overrun"}, o_err_overrun, 0);
    chk({tag, "_in_ready"}, o_in_ready, 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    i_frame_start = 1'b0;
    i_mode        = 1'b0;
    i_in_valid    = 1'b0;
    i_in_data     = '0;
    i_out_ready   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    tick();

    // Full resolution, no backpressure
    run_frame(1'b0, 1'b0, 1'b0, -1, start_cyc);
    check_frame(1'b0, 1'b1, start_cyc, 0);

    // Decimated frame started the cycle after the previous finish pulse
    run_frame(1'b1, 1'b0, 1'b0, -1, start_cyc);
    check_frame(1'b1, 1'b0, start_cyc, 0);

    // Backpressure on beat 2
    run_frame(1'b0, 1'b1, 1'b0, -1, start_cyc);
    check_frame(1'b0, 1'b0, start_cyc, 0);

    // Ignored frame start mid-frame with the mode input toggled
    run_frame(1'b0, 1'b0, 1'b1, -1, start_cyc);
    check_frame(1'b0, 1'b1, start_cyc, 1);

    // Reset after 13 accepted pixels
    run_frame(1'b0, 1'b0, 1'b0, 13, start_cyc);
    chk("pixels_before_reset", in_hs, 13);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    tick();
    rst_n      = 1'b1;
    i_in_valid = 1'b0;
    tick();
    run_frame(1'b0, 1'b0, 1'b0, -1, start_cyc);
    check_frame(1'b0, 1'b1, start_cyc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_readout_packer.md
# pixel_readout_packer

Parametrised readout stage between the pixel frame buffer and the sensor output bus. Accepts one pixel per cycle over a valid/ready stream, packs pixels into BUS_WIDTH-lane beats, and marks row starts and frame end. Supports full-resolution or 2x2-decimated readout, selected per frame, with downstream backpressure. It is the next-generation replacement for the fixed-width DATA_OUT/FRAME_FINISHED output path of SENSOR_TOP.

## Interface
Parameters:
- PIXEL_BITS, 8, bits per pixel
- ARRAY_WIDTH, 8, pixels per row; must be a multiple of 2*BUS_WIDTH
- ARRAY_HEIGHT, 8, rows per frame; must be even
- BUS_WIDTH, 4, pixels per output beat (≥1)

Ports:
- CLK  in  1  single clock for the block
- RESET  in  1  asynchronous, active-low reset
- FRAME_START  in  1  one-cycle pulse; arms capture of a new frame
- MODE  in  1  0 = full resolution, 1 = 2x2 decimate; sampled on FRAME_START
- IN_VALID  in  1  input pixel valid
- IN_READY  out  1  input pixel accepted when IN_VALID && IN_READY
- IN_DATA  in  PIXEL_BITS  pixel, raster order, row 0 col 0 first
- OUT_VALID  out  1  output beat valid
- OUT_READY  in  1  downstream accepts beat
- OUT_DATA  out  BUS_WIDTH x PIXEL_BITS  packed beat; lane 0 = earliest pixel
- OUT_ROW_START  out  1  qualifies the first beat of each output row
- OUT_FRAME_END  out  1  qualifies the last beat of the frame
- FRAME_FINISHED  out  1  one-cycle pulse after the last beat is accepted
- BUSY  out  1  high while state ≠ IDLE
- ERR_OVERRUN  out  1  one-cycle pulse when FRAME_START is ignored

## Operation
- States: IDLE, ACTIVE, DRAIN.
- IDLE: IN_READY=0. FRAME_START latches MODE and clears the counters, then the block moves to ACTIVE.
- ACTIVE: IN_READY = !OUT_VALID || OUT_READY (combinational path from OUT_READY).
  - col and row counters advance on every accepted pixel and cover the full ARRAY_WIDTH x ARRAY_HEIGHT array, including discarded pixels.
  - A pixel is kept if MODE=0, or if MODE=1 and both col and row are even.
  - Each kept pixel is written to the lane indexed by the lane counter.
  - When the lane counter reaches BUS_WIDTH-1 on a kept pixel, the beat loads into the output register with OUT_VALID=1.
  - The input pixel at the last row and last column moves the block to DRAIN.
- DRAIN: IN_READY=0. When the final beat (OUT_FRAME_END=1) is accepted, FRAME_FINISHED pulses on the next cycle and the block returns to IDLE.
- OUT_ROW_START is set on the first beat of a kept row. OUT_FRAME_END is set on the beat containing the last kept pixel.
- Beats per frame:
  - MODE=0: ARRAY_WIDTH*ARRAY_HEIGHT/BUS_WIDTH
  - MODE=1: that value divided by 4
- FRAME_START outside IDLE is ignored and ERR_OVERRUN pulses. MODE changes mid-frame have no effect.
- FRAME_START in the same cycle as the transition to IDLE is ignored and raises ERR_OVERRUN. FRAME_START is honoured only while state=IDLE.

## Timing
- Reset values (asserted immediately, asynchronously): state=IDLE; all counters 0; OUT_DATA=0; OUT_VALID, OUT_ROW_START, OUT_FRAME_END, FRAME_FINISHED, BUSY, ERR_OVERRUN, IN_READY all 0.
- Reset mid-frame discards the partial frame; nothing is replayed.
- Latency: the beat appears at OUT_VALID on the cycle after the accepted pixel that completes it.
- Throughput: 1 pixel/cycle sustained while OUT_READY=1.
- While OUT_VALID && !OUT_READY: OUT_DATA and flags hold stable, and IN_READY=0 if a beat is pending.
- FRAME_FINISHED is high exactly 1 cycle. BUSY falls in the same cycle FRAME_FINISHED rises.
- Counter widths:
  - col: $clog2(ARRAY_WIDTH)
  - row: $clog2(ARRAY_HEIGHT)
  - lane: max(1, $clog2(BUS_WIDTH))
- Counters wrap to 0 at their terminal count. Terminal detection uses an explicit compare, not overflow.

## Structure
- PixelSensorConfig package gains readout_mode_t (READ_FULL, READ_DECIMATE) and readout_state_t (IDLE, ACTIVE, DRAIN). Default parameters come from PIXEL_BITS, PIXEL_ARRAY_WIDTH, PIXEL_ARRAY_HEIGHT and OUTPUT_BUS_WIDTH.
- One sub-module, lane_packer, holds the lane counter, lane registers, output register and valid/ready logic. The top level holds the FSM, raster counters and keep logic.

## Test plan
Setup: W=8, H=4, BUS=4, PIXEL_BITS=8, pixel value = row*8+col.
- MODE=0, OUT_READY=1, IN_VALID=1 → 8 beats. Beat0 = {0,1,2,3} with ROW_START. Beat1 = {4,5,6,7}. Beat7 = {28..31} with FRAME_END. FRAME_FINISHED pulses 1 cycle after beat7 is accepted. 32 input handshakes in total.
- MODE=1 → 2 beats: {0,2,4,6} with ROW_START, then {16,18,20,22} with ROW_START and FRAME_END. All 32 inputs are still consumed.
- MODE=0 with OUT_READY=0 for 5 cycles after beat2 → OUT_DATA holds {8,9,10,11}, IN_READY=0, no pixel lost or duplicated.
- FRAME_START during ACTIVE, with MODE toggled → ERR_OVERRUN pulses for 1 cycle; the frame output is identical to scenario 1.
- RESET low after 13 accepted pixels → all outputs read 0 immediately. The next frame restarts at pixel 0, beat0 = {0,1,2,3}.
- FRAME_START in the cycle after FRAME_FINISHED → the second frame is accepted, BUSY rises, no ERR_OVERRUN.
